// File: rtl/dmux_8way1bit_deser_chip.sv
// 1-to-8 serial deserializer: collects qualified bits into a shadow register and
// publishes them on a..h as a whole frame with a one-cycle out_valid pulse.
module dmux_8way1bit_deser_chip #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  input  logic       in_valid,
  input  logic       clear,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h,
  output logic       out_valid,
  output logic [2:0] count,
  output logic       any
);

  logic [7:0] shadow_q, shadow_d;
  logic [7:0] frame_q, frame_d;
  logic [2:0] count_q, count_d;
  logic       vld_q, vld_d;
  logic [7:0] merged;

  function automatic logic [2:0] way(input logic [2:0] k);
    return MSB_FIRST ? (3'd7 - k) : k;
  endfunction

  always_comb begin
    shadow_d = shadow_q;
    frame_d  = frame_q;
    count_d  = count_q;
    vld_d    = 1'b0;
    merged   = shadow_q;
    merged[way(count_q)] = in;
    // Clear wins over an accept on the same edge, including the completing one.
    if (clear) begin
      shadow_d = 8'h00;
      count_d  = 3'd0;
    end else if (in_valid) begin
      shadow_d = merged;
      count_d  = count_q + 3'd1;
      if (count_q == 3'd7) begin
        frame_d = merged;
        vld_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= 8'h00;
      frame_q  <= 8'h00;
      count_q  <= 3'd0;
      vld_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
    end
  end

  assign {h, g, f, e, d, c, b, a} = frame_q;
  assign out_valid = vld_q;
  assign count     = count_q;
  assign any       = |frame_q;

endmodule

// File: tb/tb_dmux_8way1bit_deser_chip.sv
// Directed bench for the 1-to-8 deserializer; one instance per bit ordering.
module tb_dmux_8way1bit_deser_chip;

  logic clk = 1'b0;
  logic rst_n, in, in_valid, clear;

  logic a0, b0, c0, d0, e0, f0, g0, h0, ov0, any0;
  logic a1, b1, c1, d1, e1, f1, g1, h1, ov1, any1;
  logic [2:0] cnt0, cnt1;
  logic [7:0] frm0, frm1;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  dmux_8way1bit_deser_chip #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .clear(clear),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0), .h(h0),
    .out_valid(ov0), .count(cnt0), .any(any0)
  );

  dmux_8way1bit_deser_chip #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .clear(clear),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .h(h1),
    .out_valid(ov1), .count(cnt1), .any(any1)
  );

  assign frm0 = {h0, g0, f0, e0, d0, c0, b0, a0};
  assign frm1 = {h1, g1, f1, e1, d1, c1, b1, a1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive inputs away from the edge, then sample 1ns after the rising edge.
  task automatic cycle(input logic vi, input logic bit_i, input logic cl);
    in_valid = vi;
    in       = bit_i;
    clear    = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] seq;
    rst_n = 1'b0; in = 1'bx; in_valid = 1'b0; clear = 1'b0;

    // Reset then idle, with X on the data line
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'bx, 1'b0);
      check("rst_frame", frm0, 8'h00);
      check("rst_count", cnt0, 3'd0);
      check("rst_ov", ov0, 1'b0);
      check("rst_any", any0, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'bx, 1'b0);
      check("idle_frame", frm0, 8'h00);
      check("idle_count", cnt0, 3'd0);
      check("idle_ov", ov0, 1'b0);
      check("idle_any", any0, 1'b0);
    end

    // Frame 0,1,1,0,1,1,0,0 (index 0 first)
    seq = 8'b0011_0110;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, seq[i], 1'b0);
      check("f1_count", cnt0, (i + 1) % 8);
      check("f1_ov", ov0, (i == 7));
      if (i < 7) check("f1_hold", frm0, 8'h00);
    end
    check("f1_frame_lsb", frm0, 8'h36);
    check("f1_frame_msb", frm1, 8'h6C);
    check("f1_any", any0, 1'b1);
    check("f1_ov_msb", ov1, 1'b1);
    cycle(1'b0, 1'bx, 1'b0);
    check("f1_ov_drop", ov0, 1'b0);
    check("f1_stable", frm0, 8'h36);

    // Gapped all-ones frame
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'bx, 1'b0);
      check("gap_count", cnt0, 3'd4);
      check("gap_ov", ov0, 1'b0);
      check("gap_frame", frm0, 8'h36);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      check("gap_ov2", ov0, (i == 3));
    end
    check("gap_frame_done", frm0, 8'hFF);
    check("gap_count_done", cnt0, 3'd0);

    // Clear beats the completing accept
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0);
    check("clr_pre_count", cnt0, 3'd7);
    check("clr_pre_ov", ov0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    check("clr_ov", ov0, 1'b0);
    check("clr_count", cnt0, 3'd0);
    check("clr_frame", frm0, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      check("clr_f_ov", ov0, (i == 7));
    end
    check("clr_f_frame", frm0, 8'h00);
    check("clr_f_any", any0, 1'b0);

    // First bit only set: a for LSB-first, h for MSB-first
    seq = 8'b0000_0001;
    for (int i = 0; i < 8; i++) cycle(1'b1, seq[i], 1'b0);
    check("one_lsb", frm0, 8'h01);
    check("one_msb", frm1, 8'h80);
    check("one_any_msb", any1, 1'b1);

    // Asynchronous reset in the middle of a partial frame
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
    check("mid_count", cnt0, 3'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", cnt0, 3'd0);
    check("arst_frame_lsb", frm0, 8'h00);
    check("arst_frame_msb", frm1, 8'h00);
    check("arst_any", any1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("arst_hold", cnt1, 3'd0);
    rst_n = 1'b1;

    // MSB_FIRST=1 after reset: 1,0,0,0,0,0,0,0 -> h=1, a..g=0
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, seq[i], 1'b0);
      check("msb_ov", ov1, (i == 7));
    end
    check("msb_h", h1, 1'b1);
    check("msb_frame", frm1, 8'h80);
    check("msb_count", cnt1, 3'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
